nms_window_sequencer: RTL and testbench
=======================================

// Module: nms_window_sequencer
// PURPOSE
//  Streams raster-order gradient pixels (magnitude + 2-bit quantised direction) and builds 3x3 windows in
//  two line buffers plus a 3x3 register array. Emits one window per interior pixel, formatted for the
//  non-maximum-suppression stage. Sequences one frame per start pulse. Applies backpressure both ways.
// PARAMETERS
//  IMG_WIDTH   640  pixels per row, >= 3
//  IMG_HEIGHT  480  rows per frame, >= 3
//  MAG_W       11   magnitude bits per pixel
//  DIR_W       2    direction bits per pixel
// PORTS
//  clk            in   1          single clock, all logic rising-edge
//  rst            in   1          synchronous, active-high reset
//  start          in   1          1-cycle pulse: begin one frame (honoured only in IDLE)
//  pix_valid      in   1          input pixel valid
//  pix_ready      out  1          input pixel accepted when pix_valid & pix_ready
//  pix_magnitude  in   MAG_W      gradient magnitude
//  pix_direction  in   DIR_W      quantised direction
//  win_valid      out  1          window valid; drives both NMS magnitude-valid and direction-valid
//  win_ready      in   1          downstream accepts window
//  win_magnitude  out  9*MAG_W    window magnitudes (packing below)
//  win_direction  out  9*DIR_W    window directions (packing below)
//  busy           out  1          high in RUN and DONE
//  frame_done     out  1          1-cycle pulse when a frame has fully drained
// BEHAVIOUR
//  - Packing: element k = 3*r + c, r=0 top/oldest row, c=0 leftmost/oldest column.
//    Magnitude bits [MAG_W*k+MAG_W-1 : MAG_W*k]. Direction bits [DIR_W*k+DIR_W-1 : DIR_W*k].
//    Centre is k=4.
//  - Reset: state=IDLE, row/col counters=0, pix_ready=0, win_valid=0, busy=0, frame_done=0.
//    win_* data=0. Line buffer contents are not cleared and their value is don't-care.
//  - FSM:
//    IDLE -> RUN on start.
//    RUN -> DONE on accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
//    DONE -> IDLE once win_valid=0 or win_ready=1; frame_done pulses on that DONE->IDLE cycle.
//  - pix_ready = (state==RUN) & (!win_valid | win_ready). It is low in IDLE and DONE.
//  - On accept at (row,col):
//    * shift the window one column left;
//    * new right column = {linebuf1[col], linebuf0[col], pixel} for top/mid/bottom;
//    * linebuf1[col] <= linebuf0[col]; linebuf0[col] <= pixel;
//    * col wraps at IMG_WIDTH-1 and row increments.
//  - A window is emitted iff row>=2 & col>=2. Its centre is (row-1, col-1).
//    win_valid rises the cycle after that accept. Latency is 1 clk.
//    Count = (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows per frame.
//  - Output register holds data stable while win_valid & !win_ready.
//    It clears win_valid on handshake unless reloaded in the same cycle. Simultaneous consume and load
//    gives back-to-back windows with no bubble.
//  - Columns 0-1 of each row leave stale data from the previous row in the window. It is never emitted.
//  - start while busy is ignored. pix_valid in IDLE/DONE is not accepted.
//  - rst mid-frame: immediate IDLE, any pending window dropped, no frame_done.
//  - Counters are sized $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT). No arithmetic on pixel data.
// CONFIGURATION
//  NMS_WIN_FRAME_MARKERS_EN defined:
//  - adds outputs win_sof and win_eof (1 bit each), registered with the window data;
//  - win_sof=1 on the window centred (1,1);
//  - win_eof=1 on the window centred (IMG_HEIGHT-2, IMG_WIDTH-2);
//  - both are held with the data under stall and reset to 0.
//  Undefined: the ports do not exist. All other behaviour is identical.
// TESTING
//  1. 4x4 frame, mag=16*row+col, dir=col%4, win_ready=1.
//     -> 4 windows centred (1,1),(1,2),(2,1),(2,2).
//     -> (1,1) has k0=0x00, k4=0x11, k8=0x22.
//     -> frame_done 1 cycle after the last window.
//  2. Same frame, win_ready low for 5 cycles on window 2.
//     -> window held stable, pix_ready=0 during the stall, no window lost or duplicated.
//  3. 3x3 frame (minimum).
//     -> exactly 1 window, centre=pixel(1,1).
//     -> busy=1 from the cycle after start until frame_done.
//  4. start pulsed mid-frame.
//     -> ignored; window count still (H-2)*(W-2).
//  5. rst asserted after 7 pixels of a 4x4 frame.
//     -> next cycle IDLE, win_valid=0, no frame_done.
//     -> a fresh start then produces 4 correct windows.
//  6. NMS_WIN_FRAME_MARKERS_EN, 5x4 frame.
//     -> win_sof only on window 0, win_eof only on window 5.

Source files
------------

// File: rtl/nms_window_sequencer.sv
// 3x3 window builder for non-maximum suppression: two line buffers + window regs.
// Optional `NMS_WIN_FRAME_MARKERS_EN adds win_sof/win_eof outputs.
module nms_window_sequencer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int MAG_W      = 11,
  parameter int DIR_W      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [MAG_W-1:0]   pix_magnitude,
  input  logic [DIR_W-1:0]   pix_direction,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [9*MAG_W-1:0] win_magnitude,
  output logic [9*DIR_W-1:0] win_direction,
`ifdef NMS_WIN_FRAME_MARKERS_EN
  output logic               win_sof,
  output logic               win_eof,
`endif
  output logic               busy,
  output logic               frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int PW = MAG_W + DIR_W;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nx;
  logic   w_fdone;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  logic [PW-1:0] r_lb0 [IMG_WIDTH];
  logic [PW-1:0] r_lb1 [IMG_WIDTH];
  logic [PW-1:0] r_win [9];
  logic [PW-1:0] w_shift [9];
  logic [PW-1:0] w_pix;

  logic [9*MAG_W-1:0] w_mag;
  logic [9*DIR_W-1:0] w_dir;

  logic r_win_valid;
  logic [9*MAG_W-1:0] r_win_mag;
  logic [9*DIR_W-1:0] r_win_dir;
  logic r_frame_done;

  logic w_accept;
  logic w_last;
  logic w_load;
  logic w_last_col;

  assign pix_ready  = (r_state == S_RUN) &
                      (!r_win_valid | win_ready);
  assign w_accept   = pix_valid & pix_ready;
  assign w_last_col = (r_col == LAST_COL);
  assign w_last     = w_last_col &&
                      (r_row == LAST_ROW);
  assign w_load     = w_accept &&
                      (r_row >= RW'(2)) &&
                      (r_col >= CW'(2));
  assign w_pix      = {pix_direction, pix_magnitude};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_fdone    = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) w_state_nx = S_RUN;
      S_RUN:  if (w_accept && w_last) w_state_nx = S_DONE;
      S_DONE: begin
        if (!r_win_valid || win_ready) begin
          w_state_nx = S_IDLE;
          w_fdone    = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // New right column: two rows up, one row up, incoming pixel
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_shift[3*i]   = r_win[3*i+1];
      w_shift[3*i+1] = r_win[3*i+2];
    end
    w_shift[2] = r_lb1[r_col];
    w_shift[5] = r_lb0[r_col];
    w_shift[8] = w_pix;
  end

  always_comb begin
    w_mag = '0;
    w_dir = '0;
    for (int k = 0; k < 9; k++) begin
      w_mag[MAG_W*k +: MAG_W] = w_shift[k][MAG_W-1:0];
      w_dir[DIR_W*k +: DIR_W] = w_shift[k][PW-1:MAG_W];
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[r_col] <= r_lb0[r_col];
      r_lb0[r_col] <= w_pix;
      for (int k = 0; k < 9; k++) r_win[k] <= w_shift[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_valid <= 1'b0;
      r_win_mag   <= '0;
      r_win_dir   <= '0;
    end else if (w_load) begin
      r_win_valid <= 1'b1;
      r_win_mag   <= w_mag;
      r_win_dir   <= w_dir;
    end else if (win_ready) begin
      r_win_valid <= 1'b0;
    end
  end

`ifdef NMS_WIN_FRAME_MARKERS_EN
  logic r_sof;
  logic r_eof;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sof <= 1'b0;
      r_eof <= 1'b0;
    end else if (w_load) begin
      r_sof <= (r_row == RW'(2)) &&
               (r_col == CW'(2));
      r_eof <= w_last;
    end
  end

  assign win_sof = r_sof;
  assign win_eof = r_eof;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_frame_done <= 1'b0;
    else     r_frame_done <= w_fdone;
  end

  assign win_valid     = r_win_valid;
  assign win_magnitude = r_win_mag;
  assign win_direction = r_win_dir;
  assign busy          = (r_state != S_IDLE);
  assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_nms_window_sequencer.sv
// Scoreboard bench for nms_window_sequencer: 4x4, 3x3 and 5x4 instances.
// Pixel model: magnitude = 16*row + col, direction = col % 4.
module tb_nms_window_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] start = '0;
  logic pix_valid = 1'b0;
  logic [10:0] pix_magnitude = '0;
  logic [1:0] pix_direction = '0;
  logic win_ready = 1'b1;

  logic pr [3];
  logic wv [3];
  logic bz [3];
  logic fd [3];
  logic [98:0] wm [3];
  logic [17:0] wd [3];
  logic sof [3];
  logic eof [3];

  logic [1:0] sel = '0;
  logic m_pr, m_wv, m_bz, m_fd, m_sof, m_eof;
  logic [98:0] m_wm;
  logic [17:0] m_wd;

  typedef struct {
    logic [98:0] mag;
    logic [17:0] dir;
    logic sof;
    logic eof;
  } exp_t;

  exp_t sb [$];
  int g_checks = 0;
  int g_errors = 0;
  int g_cyc = 0;
  int g_nwin = 0;
  int g_last_hs = 0;
  int g_sof_n = 0;
  int g_eof_n = 0;
  bit g_mon = 1'b0;
  logic [98:0] g_first;

  always #5 clk = ~clk;
  always @(posedge clk) g_cyc++;

  assign m_pr = pr[sel];
  assign m_wv = wv[sel];
  assign m_bz = bz[sel];
  assign m_fd = fd[sel];
  assign m_wm = wm[sel];
  assign m_wd = wd[sel];
  assign m_sof = sof[sel];
  assign m_eof = eof[sel];

`ifdef NMS_WIN_FRAME_MARKERS_EN
  `define MARK_PORTS(i) .win_sof(sof[i]), .win_eof(eof[i]),
`else
  `define MARK_PORTS(i)
  initial begin
    for (int i = 0; i < 3; i++) begin
      sof[i] = 1'b0;
      eof[i] = 1'b0;
    end
  end
`endif

  nms_window_sequencer #(.IMG_WIDTH(4), .IMG_HEIGHT(4),
    .MAG_W(11), .DIR_W(2)) u_d0 (
    .clk(clk), .rst(rst), .start(start[0]),
    .pix_valid(pix_valid), .pix_ready(pr[0]),
    .pix_magnitude(pix_magnitude),
    .pix_direction(pix_direction),
    .win_valid(wv[0]), .win_ready(win_ready),
    .win_magnitude(wm[0]), .win_direction(wd[0]),
    `MARK_PORTS(0)
    .busy(bz[0]), .frame_done(fd[0]));

  nms_window_sequencer #(.IMG_WIDTH(3), .IMG_HEIGHT(3),
    .MAG_W(11), .DIR_W(2)) u_d1 (
    .clk(clk), .rst(rst), .start(start[1]),
    .pix_valid(pix_valid), .pix_ready(pr[1]),
    .pix_magnitude(pix_magnitude),
    .pix_direction(pix_direction),
    .win_valid(wv[1]), .win_ready(win_ready),
    .win_magnitude(wm[1]), .win_direction(wd[1]),
    `MARK_PORTS(1)
    .busy(bz[1]), .frame_done(fd[1]));

  nms_window_sequencer #(.IMG_WIDTH(4), .IMG_HEIGHT(5),
    .MAG_W(11), .DIR_W(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start[2]),
    .pix_valid(pix_valid), .pix_ready(pr[2]),
    .pix_magnitude(pix_magnitude),
    .pix_direction(pix_direction),
    .win_valid(wv[2]), .win_ready(win_ready),
    .win_magnitude(wm[2]), .win_direction(wd[2]),
    `MARK_PORTS(2)
    .busy(bz[2]), .frame_done(fd[2]));

  function automatic exp_t mk(input int cr, input int cc,
                              input int h, input int w);
    exp_t e;
    int k;
    e.mag = '0;
    e.dir = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        k = 3*i + j;
        e.mag[11*k +: 11] = 11'(16*(cr-1+i) + (cc-1+j));
        e.dir[2*k +: 2] = 2'((cc-1+j) % 4);
      end
    end
    e.sof = (cr == 1 && cc == 1);
    e.eof = (cr == h-2 && cc == w-2);
    return e;
  endfunction

  // Scoreboard pop on every window handshake
  always @(negedge clk) begin
    exp_t e;
    if (g_mon && m_wv && win_ready) begin
      g_checks++;
      if (sb.size() == 0) begin
        g_errors++;
        $display("FAIL win_extra: got mag=%h, none expected", m_wm);
      end else begin
        e = sb.pop_front();
        if (m_wm !== e.mag || m_wd !== e.dir) begin
          g_errors++;
          $display("FAIL win_data #%0d: got %h/%h want %h/%h",
                   g_nwin, m_wm, m_wd, e.mag, e.dir);
        end
`ifdef NMS_WIN_FRAME_MARKERS_EN
        g_checks++;
        if (m_sof !== e.sof || m_eof !== e.eof) begin
          g_errors++;
          $display("FAIL win_marks #%0d: got %b%b want %b%b",
                   g_nwin, m_sof, m_eof, e.sof, e.eof);
        end
`endif
      end
      if (g_nwin == 0) g_first = m_wm;
      if (m_sof === 1'b1) g_sof_n++;
      if (m_eof === 1'b1) g_eof_n++;
      g_nwin++;
      g_last_hs = g_cyc;
    end
  end

  task automatic run_frame(input int s, input int h, input int w,
                           input int stall_win, input int mid_start,
                           input int abort_n);
    int r, c, acc, cyc, stall_left;
    bit fdn;
    logic [98:0] held;
    r = 0; c = 0; acc = 0; cyc = 0;
    stall_left = 5; fdn = 1'b0; held = '0;
    sel = 2'(s);
    g_nwin = 0; g_sof_n = 0; g_eof_n = 0;
    sb.delete();
    g_mon = 1'b1;
    @(posedge clk); #1;
    start[s] = 1'b1;
    win_ready = 1'b1;
    @(posedge clk); #1;
    start[s] = 1'b0;
    while (!fdn && cyc < 400 &&
           !(abort_n >= 0 && acc == abort_n)) begin
      pix_valid = (r < h);
      pix_magnitude = 11'(16*r + c);
      pix_direction = 2'(c % 4);
      start[s] = (cyc == mid_start);
      win_ready = 1'b1;
      if (stall_win >= 0 && g_nwin == stall_win &&
          m_wv && stall_left > 0) begin
        win_ready = 1'b0;
        stall_left--;
        held = m_wm;
      end
      @(negedge clk);
      if (!win_ready) begin
        g_checks++;
        if (m_wm !== held || m_pr !== 1'b0 || m_wv !== 1'b1) begin
          g_errors++;
          $display("FAIL stall_hold: mag=%h pr=%b wv=%b want %h 0 1",
                   m_wm, m_pr, m_wv, held);
        end
      end
      g_checks++;
      if (m_fd === 1'b1) begin
        fdn = 1'b1;
        if (g_cyc - g_last_hs != 1 || m_bz !== 1'b0) begin
          g_errors++;
          $display("FAIL done_timing: lag=%0d busy=%b want 1 0",
                   g_cyc - g_last_hs, m_bz);
        end
      end else if (m_bz !== 1'b1) begin
        g_errors++;
        $display("FAIL busy_run: got %b want 1 (cyc %0d)", m_bz, cyc);
      end
      if (pix_valid && m_pr) begin
        if (r >= 2 && c >= 2) sb.push_back(mk(r-1, c-1, h, w));
        acc++;
        if (c == w-1) begin c = 0; r++; end
        else c++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    start[s] = 1'b0;
    win_ready = 1'b1;
    if (abort_n < 0) begin
      g_checks++;
      if (!fdn) begin
        g_errors++;
        $display("FAIL frame_timeout: no frame_done, want pulse");
      end
      @(negedge clk);
      g_checks++;
      if (m_fd !== 1'b0) begin
        g_errors++;
        $display("FAIL done_pulse: got %b want 0 after pulse", m_fd);
      end
      g_checks++;
      if (g_nwin != (h-2)*(w-2) || sb.size() != 0) begin
        g_errors++;
        $display("FAIL win_count: got %0d left %0d want %0d 0",
                 g_nwin, sb.size(), (h-2)*(w-2));
      end
      if (stall_win >= 0) begin
        g_checks++;
        if (stall_left != 0) begin
          g_errors++;
          $display("FAIL stall_len: left %0d want 0", stall_left);
        end
      end
      g_mon = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      g_checks++;
      if (pr[s] !== 1'b0 || wv[s] !== 1'b0 || bz[s] !== 1'b0 ||
          fd[s] !== 1'b0 || wm[s] !== '0 || wd[s] !== '0) begin
        g_errors++;
        $display("FAIL reset_state[%0d]: %b%b%b%b %h %h want 0",
                 s, pr[s], wv[s], bz[s], fd[s], wm[s], wd[s]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    run_frame(0, 4, 4, -1, -1, -1);
    g_checks++;
    if (g_first[10:0] !== 11'h00 || g_first[54:44] !== 11'h11 ||
        g_first[98:88] !== 11'h22) begin
      g_errors++;
      $display("FAIL first_win: k0=%h k4=%h k8=%h want 00 11 22",
               g_first[10:0], g_first[54:44], g_first[98:88]);
    end
  endtask

  task automatic test_stall;
    run_frame(0, 4, 4, 1, -1, -1);
  endtask

  task automatic test_min_frame;
    @(negedge clk);
    g_checks++;
    if (bz[1] !== 1'b0) begin
      g_errors++;
      $display("FAIL idle_busy: got %b want 0", bz[1]);
    end
    run_frame(1, 3, 3, -1, -1, -1);
  endtask

  task automatic test_mid_start;
    run_frame(0, 4, 4, -1, 6, -1);
  endtask

  task automatic test_reset_mid;
    run_frame(0, 4, 4, -1, -1, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    g_mon = 1'b0;
    @(negedge clk);
    g_checks++;
    if (m_bz !== 1'b0 || m_wv !== 1'b0 || m_pr !== 1'b0 ||
        m_fd !== 1'b0) begin
      g_errors++;
      $display("FAIL abort_state: bz=%b wv=%b pr=%b fd=%b want 0",
               m_bz, m_wv, m_pr, m_fd);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      g_checks++;
      if (m_fd !== 1'b0 || m_wv !== 1'b0) begin
        g_errors++;
        $display("FAIL abort_quiet: fd=%b wv=%b want 0 0", m_fd, m_wv);
      end
    end
    run_frame(0, 4, 4, -1, -1, -1);
  endtask

  task automatic test_markers;
    run_frame(2, 5, 4, -1, -1, -1);
`ifdef NMS_WIN_FRAME_MARKERS_EN
    g_checks++;
    if (g_sof_n != 1 || g_eof_n != 1) begin
      g_errors++;
      $display("FAIL marker_count: sof=%0d eof=%0d want 1 1",
               g_sof_n, g_eof_n);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_min_frame();
    test_mid_start();
    test_reset_mid();
    test_markers();
    $display("Simulation finished: %0d checks, %0d errors",
             g_checks, g_errors);
    $finish;
  end

endmodule
